// File: rtl/king_move_collector.sv
// Collects king target squares from the move generator over a four-phase req/ack
// handshake, drops own-piece and duplicate squares, and streams survivors out.
module king_move_collector #(
    parameter int MAX_MOVES = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      own_mask,
    output logic             gen_req,
    input  logic             gen_ack,
    input  logic             gen_valid,
    input  logic [5:0]       gen_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_pos,
    output logic             out_last,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    localparam int IDX_W = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);

    typedef enum logic [1:0] {IDLE, COLLECT, RELEASE, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [63:0]      seen_q;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [5:0]       mem_q [MAX_MOVES];
    logic             xfer, accept, keep;
    logic             gen_req_d, out_valid_d, out_last_d, done_d, busy_d;
    logic [5:0]       out_pos_d;

    // Output handshake: an entry transfers on a rising edge where out_valid && out_ready;
    // while out_valid && !out_ready, out_pos and out_last hold their values.
    assign xfer   = out_valid & out_ready;
    assign accept = (state_q == COLLECT) && gen_valid && !own_mask[gen_pos] && !seen_q[gen_pos];
    assign keep   = accept && (count != MAX_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COLLECT;
            COLLECT: if (gen_ack) state_d = RELEASE;
            RELEASE: if (!gen_ack) state_d = (count != '0) ? DRAIN : IDLE;
            DRAIN:   if (xfer && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (state_q == IDLE && start) rd_ptr_d = '0;
        else if (xfer)                rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        gen_req_d   = (state_d == COLLECT);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DRAIN);
        out_pos_d   = out_pos;
        if (state_d == DRAIN) out_pos_d = mem_q[rd_ptr_d[IDX_W-1:0]];
        out_last_d  = (state_d == DRAIN) && (rd_ptr_d == count - CNT_W'(1));
        done_d      = ((state_q == RELEASE) && !gen_ack && (count == '0)) || (xfer && out_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_req   <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_pos   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            gen_req   <= gen_req_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            out_pos   <= out_pos_d;
            out_last  <= out_last_d;
            done      <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            seen_q   <= '0;
            overflow <= 1'b0;
            rd_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            if (state_q == IDLE && start) begin
                count    <= '0;
                seen_q   <= '0;
                overflow <= 1'b0;
            end else if (accept) begin
                if (keep) begin
                    count           <= count + CNT_W'(1);
                    seen_q[gen_pos] <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Buffer contents need no reset: entries are only read below count.
    always_ff @(posedge clk) begin
        if (keep) mem_q[count[IDX_W-1:0]] <= gen_pos;
    end
endmodule

// File: tb/tb_king_move_collector.sv
// Directed and randomized bench for king_move_collector: a generator model feeds
// squares, a reference filter predicts survivors, and the drain phase checks them.
module tb_king_move_collector;
    localparam int MAX_MOVES = 8;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst, start, gen_ack, gen_valid, out_ready;
    logic [63:0]      own_mask;
    logic [5:0]       gen_pos;
    logic             gen_req, out_valid, out_last, busy, done, overflow;
    logic [5:0]       out_pos;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [5:0]  exp_q [$];
    logic [63:0] seen_m;
    int          cnt_m;
    logic        ovf_m;
    logic [5:0]  stim [16];
    int          stim_n;

    king_move_collector #(.MAX_MOVES(MAX_MOVES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .own_mask(own_mask),
        .gen_req(gen_req), .gen_ack(gen_ack), .gen_valid(gen_valid), .gen_pos(gen_pos),
        .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos), .out_last(out_last),
        .count(count), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference filter applied as each square is driven.
    task automatic model_square(input logic [5:0] sq);
        if (own_mask[sq] || seen_m[sq]) return;
        if (cnt_m == MAX_MOVES) begin
            ovf_m = 1'b1;
            return;
        end
        exp_q.push_back(sq);
        seen_m[sq] = 1'b1;
        cnt_m++;
    endtask

    task automatic do_start();
        seen_m = '0;
        cnt_m  = 0;
        ovf_m  = 1'b0;
        exp_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", 64'(busy), 64'(1));
        check("start_ovf_clear", 64'(overflow), 64'(0));
    endtask

    task automatic gen_txn(input bit ack_with_last);
        int guard = 0;
        while (!gen_req && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("req_rise", 64'(gen_req), 64'(1));
        for (int i = 0; i < stim_n; i++) begin
            gen_valid = 1'b1;
            gen_pos   = stim[i];
            model_square(stim[i]);
            if (ack_with_last && i == stim_n - 1) gen_ack = 1'b1;
            @(posedge clk); #1;
        end
        gen_valid = 1'b0;
        if (!ack_with_last) begin
            gen_ack = 1'b1;
            @(posedge clk); #1;
        end
        guard = 0;
        while (gen_req && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("req_fall", 64'(gen_req), 64'(0));
        gen_ack = 1'b0;
    endtask

    task automatic drain(input int stall_idx, input int stall_len);
        int k = 0;
        int stalled = 0;
        int guard = 0;
        int total = exp_q.size();
        while (exp_q.size() > 0 && guard < 200) begin
            @(posedge clk); #1;
            if (out_valid && k == stall_idx && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (out_valid && out_ready) begin
                check("out_pos", 64'(out_pos), 64'(exp_q[0]));
                check("out_last", 64'(out_last), 64'(exp_q.size() == 1));
                void'(exp_q.pop_front());
                k++;
            end else if (out_valid) begin
                check("hold_pos", 64'(out_pos), 64'(exp_q[0]));
            end
            guard++;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
        check("xfer_total", 64'(k), 64'(total));
        @(negedge clk);
        check("end_valid", 64'(out_valid), 64'(0));
        check("end_done", 64'(done), 64'(1));
        check("end_busy", 64'(busy), 64'(0));
        out_ready = 1'b0;
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(0));
    endtask

    task automatic run_txn(input bit ack_with_last, input int stall_idx, input int stall_len);
        do_start();
        gen_txn(ack_with_last);
        check("count", 64'(count), 64'(cnt_m));
        check("overflow", 64'(overflow), 64'(ovf_m));
        if (cnt_m == 0) begin
            @(negedge clk);
            check("empty_done_early", 64'(done), 64'(0));
            @(negedge clk);
            check("empty_done", 64'(done), 64'(1));
            check("empty_valid", 64'(out_valid), 64'(0));
            check("empty_busy", 64'(busy), 64'(0));
            @(negedge clk);
            check("empty_done_pulse", 64'(done), 64'(0));
            check("empty_valid2", 64'(out_valid), 64'(0));
        end else begin
            drain(stall_idx, stall_len);
        end
        check("count_stable", 64'(count), 64'(cnt_m));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; gen_ack = 1'b0; gen_valid = 1'b0;
        gen_pos = '0; out_ready = 1'b0; own_mask = '0;
        #1;
        check("rst_req", 64'(gen_req), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_pos", 64'(out_pos), 64'(0));
        check("rst_flags", 64'({out_last, done, overflow}), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic capture around a centre square.
        stim = '{6'd27, 6'd28, 6'd29, 6'd35, 6'd37, 6'd43, 6'd44, 6'd45,
                 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        stim_n = 8;
        run_txn(1'b0, -1, 0);

        // Own pieces and duplicates, last square arriving with ack.
        own_mask = 64'h0000_0000_0000_0102;
        stim[0] = 6'd1; stim[1] = 6'd8; stim[2] = 6'd9; stim[3] = 6'd9; stim[4] = 6'd0;
        stim_n = 5;
        run_txn(1'b1, -1, 0);

        // Everything owned: nothing to drain.
        own_mask = '1;
        stim[0] = 6'd3; stim[1] = 6'd4; stim[2] = 6'd5;
        stim_n = 3;
        run_txn(1'b0, -1, 0);

        // Nine free squares into an eight-entry buffer, with backpressure.
        own_mask = '0;
        for (int i = 0; i < 9; i++) stim[i] = 6'(i);
        stim_n = 9;
        run_txn(1'b0, 1, 3);
        check("ovf_sticky", 64'(overflow), 64'(1));

        // Asynchronous reset in the middle of a collection.
        do_start();
        for (int i = 0; i < 3; i++) begin
            gen_valid = 1'b1;
            gen_pos   = 6'(10 + i);
            @(posedge clk); #1;
        end
        gen_valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'(3));
        #2 rst = 1'b1;
        #1;
        check("async_req", 64'(gen_req), 64'(0));
        check("async_busy", 64'(busy), 64'(0));
        check("async_count", 64'(count), 64'(0));
        check("async_flags", 64'({out_valid, done, overflow}), 64'(0));
        #1 rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("post_rst_idle", 64'({busy, gen_req}), 64'(0));

        // Clean transaction after reset, then randomized runs.
        stim[0] = 6'd10; stim[1] = 6'd11; stim[2] = 6'd12; stim[3] = 6'd18;
        stim_n = 4;
        run_txn(1'b0, 0, 2);
        for (int r = 0; r < 5; r++) begin
            own_mask = {$urandom, $urandom} & {$urandom, $urandom};
            stim_n = $urandom_range(3, 12);
            for (int i = 0; i < stim_n; i++) stim[i] = 6'($urandom_range(0, 63));
            run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
